gmii_preamble_stripper: RTL and testbench



---
 rtl/gmii_preamble_stripper_pkg.sv | 16 +
 rtl/gmii_hold_buffer.sv | 44 ++++
 rtl/gmii_preamble_stripper.sv | 177 +++++++++++++++++
 tb/tb_gmii_preamble_stripper.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_preamble_stripper_pkg.sv
// Shared constants for the GMII capture front end: preamble/SFD bytes, FCS length
// and the stripper FSM state encoding.
package gmii_preamble_stripper_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t GMII_PREAMBLE = 8'h55;
    localparam byte_t GMII_SFD      = 8'hD5;
    localparam int    FCS_LEN       = 4;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_PAYLOAD  = 2'd2;
    localparam logic [1:0] ST_DROP     = 2'd3;

endpackage

// File: rtl/gmii_hold_buffer.sv
// Byte shift register with per-entry valid bits; exposes the oldest entry so the
// caller can delay payload by DEPTH bytes and discard whatever is left on flush.
module gmii_hold_buffer
    import gmii_preamble_stripper_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push_i,
    input  logic  flush_i,
    input  byte_t data_i,
    output byte_t oldest_data_o,
    output logic  oldest_valid_o
);

    byte_t            data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_q <= '0;
        end else if (push_i) begin
            valid_q[0] <= 1'b1;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Data needs no reset: it is only observed through the valid bits.
    always_ff @(posedge clk) begin
        if (push_i) begin
            data_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign oldest_data_o  = data_q[DEPTH-1];
    assign oldest_valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/gmii_preamble_stripper.sv
// Validates GMII preamble/SFD, strips it and emits a byte AXI-Stream with SFD timestamp.
// Define GMII_STRIP_FCS_EN to hold five bytes and drop the trailing FCS.
module gmii_preamble_stripper
    import gmii_preamble_stripper_pkg::*;
#(
    parameter int TS_WIDTH     = 64,
    parameter int CNT_WIDTH    = 32,
    parameter int PREAMBLE_MIN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           gmii_rxd,
    input  logic                 gmii_rx_dv,
    input  logic                 gmii_rx_er,
    input  logic [TS_WIDTH-1:0]  ts_in,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [TS_WIDTH-1:0]  m_axis_ts,
    output logic                 m_axis_ts_valid,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] error_count
);

`ifdef GMII_STRIP_FCS_EN
    localparam int HOLD_DEPTH = FCS_LEN + 1;
`else
    localparam int HOLD_DEPTH = 1;
`endif

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [1:0]           state_q, state_d;
    logic [2:0]           pre_cnt_q, pre_cnt_d;
    logic                 err_q, err_d;
    logic                 first_q, first_d;
    logic                 after_rst_q;
    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] error_cnt_q, error_cnt_d;

    logic  hold_push, hold_flush, hold_valid;
    byte_t hold_data;
    logic  emit, emit_last, count_frame, count_error;

    gmii_hold_buffer #(
        .DEPTH(HOLD_DEPTH)
    ) u_hold (
        .clk           (clk),
        .rst           (rst),
        .push_i        (hold_push),
        .flush_i       (hold_flush),
        .data_i        (gmii_rxd),
        .oldest_data_o (hold_data),
        .oldest_valid_o(hold_valid)
    );

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        err_d       = err_q;
        first_d     = first_q;
        ts_d        = ts_q;
        hold_push   = 1'b0;
        hold_flush  = 1'b0;
        emit        = 1'b0;
        emit_last   = 1'b0;
        count_frame = 1'b0;
        count_error = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The first byte seen after reset may be mid-frame; drop it silently.
                if (gmii_rx_dv) begin
                    if (after_rst_q) begin
                        state_d = ST_DROP;
                    end else if (gmii_rxd == GMII_PREAMBLE) begin
                        state_d   = ST_PREAMBLE;
                        pre_cnt_d = 3'd1;
                    end else begin
                        state_d     = ST_DROP;
                        count_error = 1'b1;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_d     = ST_IDLE;
                    count_error = 1'b1;
                end else if (gmii_rx_er) begin
                    state_d     = ST_DROP;
                    count_error = 1'b1;
                end else if (gmii_rxd == GMII_PREAMBLE) begin
                    if (pre_cnt_q != 3'd7) begin
                        pre_cnt_d = pre_cnt_q + 3'd1;
                    end
                end else if (gmii_rxd == GMII_SFD && int'(pre_cnt_q) >= PREAMBLE_MIN) begin
                    state_d = ST_PAYLOAD;
                    ts_d    = ts_in;
                    err_d   = 1'b0;
                    first_d = 1'b1;
                end else begin
                    state_d     = ST_DROP;
                    count_error = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                // A byte leaves the buffer only once it is full; on dv fall the rest is FCS.
                if (gmii_rx_dv) begin
                    hold_push = 1'b1;
                    emit      = hold_valid;
                    if (gmii_rx_er) begin
                        err_d = 1'b1;
                    end
                end else begin
                    hold_flush = 1'b1;
                    state_d    = ST_IDLE;
                    if (hold_valid) begin
                        emit      = 1'b1;
                        emit_last = 1'b1;
                        if (err_q) begin
                            count_error = 1'b1;
                        end else begin
                            count_frame = 1'b1;
                        end
                    end else begin
                        count_error = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (!gmii_rx_dv) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (emit) begin
            first_d = 1'b0;
        end
        frame_cnt_d = count_frame ? frame_cnt_q + CNT_ONE : frame_cnt_q;
        error_cnt_d = count_error ? error_cnt_q + CNT_ONE : error_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pre_cnt_q   <= '0;
            err_q       <= 1'b0;
            first_q     <= 1'b0;
            after_rst_q <= 1'b1;
            ts_q        <= '0;
            frame_cnt_q <= '0;
            error_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            err_q       <= err_d;
            first_q     <= first_d;
            after_rst_q <= 1'b0;
            ts_q        <= ts_d;
            frame_cnt_q <= frame_cnt_d;
            error_cnt_q <= error_cnt_d;
        end
    end

    // Outputs follow the current GMII cycle; reset forces them quiet immediately.
    assign m_axis_tvalid   = emit & ~rst;
    assign m_axis_tdata    = m_axis_tvalid ? hold_data : 8'h00;
    assign m_axis_tlast    = emit_last & ~rst;
    assign m_axis_tuser    = m_axis_tlast & err_q;
    assign m_axis_ts_valid = m_axis_tvalid & first_q;
    assign m_axis_ts       = ts_q;
    assign frame_count     = frame_cnt_q;
    assign error_count     = error_cnt_q;

endmodule

// File: tb/tb_gmii_preamble_stripper.sv
// Directed bench for gmii_preamble_stripper; expectations adapt to GMII_STRIP_FCS_EN.
module tb_gmii_preamble_stripper;

`ifdef GMII_STRIP_FCS_EN
    localparam int STRIP = 4;
`else
    localparam int STRIP = 0;
`endif
    localparam logic [63:0] TS_BASE = 64'hA5A5_0000_1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic [63:0] ts_in = 64'h0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_ts_valid;
    logic [63:0] m_axis_ts;
    logic [31:0] frame_count, error_count;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int tsCnt = 0;
    int idleViol = 0;

    logic [7:0]  beatData [$];
    logic        beatLast [$];
    logic        beatUser [$];
    int          beatCyc [$];
    logic [63:0] tsVals [$];
    int          tsBeat [$];

    gmii_preamble_stripper dut (
        .clk            (clk),
        .rst            (rst),
        .gmii_rxd       (gmii_rxd),
        .gmii_rx_dv     (gmii_rx_dv),
        .gmii_rx_er     (gmii_rx_er),
        .ts_in          (ts_in),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_ts      (m_axis_ts),
        .m_axis_ts_valid(m_axis_ts_valid),
        .frame_count    (frame_count),
        .error_count    (error_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Beats are recorded mid-cycle, away from the sampling edge.
    always @(negedge clk) begin
        if (m_axis_tvalid === 1'b1) begin
            beatData.push_back(m_axis_tdata);
            beatLast.push_back(m_axis_tlast);
            beatUser.push_back(m_axis_tuser);
            beatCyc.push_back(cyc);
        end else if (m_axis_tdata !== 8'h00 || m_axis_tlast !== 1'b0 || m_axis_ts_valid !== 1'b0) begin
            idleViol++;
        end
        if (m_axis_ts_valid === 1'b1) begin
            tsVals.push_back(m_axis_ts);
            tsBeat.push_back(beatData.size() - 1);
        end
    end

    task automatic clearQueues();
        beatData.delete(); beatLast.delete(); beatUser.delete(); beatCyc.delete();
        tsVals.delete(); tsBeat.delete();
        idleViol = 0;
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        @(posedge clk); #1;
        rst = 1'b0;
        gmii_rxd = d; gmii_rx_dv = dv; gmii_rx_er = er;
        tsCnt++;
        ts_in = TS_BASE + 64'(tsCnt);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        clearQueues();
    endtask

    task automatic sendFrame(input int nPre, input int len, input logic [7:0] first, input int errIdx,
                             output logic [63:0] expTs, output int firstCyc);
        for (int i = 0; i < nPre; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        expTs = ts_in;
        firstCyc = 0;
        for (int i = 0; i < len; i++) begin
            drive(8'(int'(first) + i), 1'b1, i == errIdx);
            if (i == 0) firstCyc = cyc;
        end
        drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; gmii_rx_dv = 1'b1; gmii_rxd = 8'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_ts_valid} !== 4'b0000) begin
            mismatched++; $display("[TB] FAIL reset_flags got %b want 0000", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_ts_valid});
        end
        #1 gmii_rx_dv = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        compared++;
        if (m_axis_tdata !== 8'h00) begin
            mismatched++; $display("[TB] FAIL reset_tdata got %h want 00", m_axis_tdata);
        end
        compared++;
        if (m_axis_ts !== 64'h0) begin
            mismatched++; $display("[TB] FAIL reset_ts got %h want 0", m_axis_ts);
        end
        compared++;
        if (frame_count !== 32'd0 || error_count !== 32'd0) begin
            mismatched++; $display("[TB] FAIL reset_counts got %0d/%0d want 0/0", frame_count, error_count);
        end
    endtask

    task automatic test_good_frame();
        logic [63:0] expTs;
        int firstCyc;
        int n = 60 - STRIP;
        int lastCnt = 0;
        doReset();
        sendFrame(7, 60, 8'h01, -1, expTs, firstCyc);
        idle(2);
        compared++;
        if (beatData.size() != n) begin
            mismatched++; $display("[TB] FAIL good_beats got %0d want %0d", beatData.size(), n);
        end else begin
            for (int k = 0; k < n; k++) begin
                compared++;
                if (beatData[k] !== 8'(k + 1) || beatLast[k] !== (k == n - 1)) begin
                    mismatched++; $display("[TB] FAIL good_beat%0d got %h/%b want %h/%b", k, beatData[k], beatLast[k], 8'(k + 1), k == n - 1);
                end
                if (beatLast[k]) lastCnt++;
            end
            compared++;
            if (beatUser[n-1] !== 1'b0) begin
                mismatched++; $display("[TB] FAIL good_tuser got %b want 0", beatUser[n-1]);
            end
            compared++;
            if (beatCyc[0] - firstCyc != 1 + STRIP) begin
                mismatched++; $display("[TB] FAIL good_latency got %0d want %0d", beatCyc[0] - firstCyc, 1 + STRIP);
            end
        end
        compared++;
        if (lastCnt != 1) begin
            mismatched++; $display("[TB] FAIL good_tlast_count got %0d want 1", lastCnt);
        end
        compared++;
        if (tsVals.size() != 1 || tsBeat.size() != 1) begin
            mismatched++; $display("[TB] FAIL good_ts_pulses got %0d want 1", tsVals.size());
        end else begin
            compared++;
            if (tsVals[0] !== expTs || tsBeat[0] != 0) begin
                mismatched++; $display("[TB] FAIL good_ts got %h@%0d want %h@0", tsVals[0], tsBeat[0], expTs);
            end
        end
        compared++;
        if (frame_count !== 32'd1 || error_count !== 32'd0) begin
            mismatched++; $display("[TB] FAIL good_counts got %0d/%0d want 1/0", frame_count, error_count);
        end
        compared++;
        if (idleViol != 0) begin
            mismatched++; $display("[TB] FAIL good_idle_quiet got %0d want 0", idleViol);
        end
    endtask

    task automatic test_payload_error();
        logic [63:0] expTs;
        int firstCyc;
        int n = 60 - STRIP;
        doReset();
        sendFrame(7, 60, 8'h01, 9, expTs, firstCyc);
        idle(2);
        compared++;
        if (beatData.size() != n) begin
            mismatched++; $display("[TB] FAIL perr_beats got %0d want %0d", beatData.size(), n);
        end else begin
            compared++;
            if (beatLast[n-1] !== 1'b1 || beatUser[n-1] !== 1'b1 || beatData[n-1] !== 8'(n)) begin
                mismatched++; $display("[TB] FAIL perr_last got %h/%b/%b want %h/1/1", beatData[n-1], beatLast[n-1], beatUser[n-1], 8'(n));
            end
        end
        compared++;
        if (frame_count !== 32'd0 || error_count !== 32'd1) begin
            mismatched++; $display("[TB] FAIL perr_counts got %0d/%0d want 0/1", frame_count, error_count);
        end
    endtask

    task automatic test_bad_preamble();
        logic [63:0] expTs;
        int firstCyc;
        int n = 10 - STRIP;
        doReset();
        drive(8'h55, 1'b1, 1'b0); drive(8'h55, 1'b1, 1'b0); drive(8'hAA, 1'b1, 1'b0);
        drive(8'h11, 1'b1, 1'b0); drive(8'h22, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (beatData.size() != 0 || error_count !== 32'd1) begin
            mismatched++; $display("[TB] FAIL badpre got beats=%0d err=%0d want 0/1", beatData.size(), error_count);
        end
        sendFrame(7, 10, 8'h80, -1, expTs, firstCyc);
        idle(2);
        compared++;
        if (beatData.size() != n) begin
            mismatched++; $display("[TB] FAIL badpre_next_beats got %0d want %0d", beatData.size(), n);
        end else begin
            compared++;
            if (beatData[n-1] !== 8'(8'h80 + n - 1) || beatLast[n-1] !== 1'b1) begin
                mismatched++; $display("[TB] FAIL badpre_next_last got %h/%b want %h/1", beatData[n-1], beatLast[n-1], 8'(8'h80 + n - 1));
            end
        end
        compared++;
        if (frame_count !== 32'd1 || error_count !== 32'd1) begin
            mismatched++; $display("[TB] FAIL badpre_counts got %0d/%0d want 1/1", frame_count, error_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ts1, ts2;
        int c1, c2;
        int n = 64 - STRIP;
        int lastCnt = 0;
        int dataErr = 0;
        doReset();
        sendFrame(7, 64, 8'h00, -1, ts1, c1);
        sendFrame(7, 64, 8'h40, -1, ts2, c2);
        idle(2);
        compared++;
        if (beatData.size() != 2 * n) begin
            mismatched++; $display("[TB] FAIL b2b_beats got %0d want %0d", beatData.size(), 2 * n);
        end else begin
            for (int f = 0; f < 2; f++) begin
                for (int k = 0; k < n; k++) begin
                    if (beatData[f*n+k] !== 8'(f * 64 + k)) dataErr++;
                    if (beatLast[f*n+k]) lastCnt++;
                end
            end
            compared++;
            if (dataErr != 0) begin
                mismatched++; $display("[TB] FAIL b2b_data got %0d bad bytes want 0", dataErr);
            end
            compared++;
            if (lastCnt != 2 || beatLast[n-1] !== 1'b1 || beatLast[2*n-1] !== 1'b1) begin
                mismatched++; $display("[TB] FAIL b2b_tlast got %0d want 2 at ends", lastCnt);
            end
        end
        compared++;
        if (tsVals.size() != 2) begin
            mismatched++; $display("[TB] FAIL b2b_ts_pulses got %0d want 2", tsVals.size());
        end else begin
            compared++;
            if (tsVals[0] !== ts1 || tsVals[1] !== ts2 || tsBeat[1] != n) begin
                mismatched++; $display("[TB] FAIL b2b_ts got %h %h@%0d want %h %h@%0d", tsVals[0], tsVals[1], tsBeat[1], ts1, ts2, n);
            end
        end
        compared++;
        if (frame_count !== 32'd2 || error_count !== 32'd0) begin
            mismatched++; $display("[TB] FAIL b2b_counts got %0d/%0d want 2/0", frame_count, error_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] expTs;
        int firstCyc;
        int preBeats;
        int lastCnt = 0;
        doReset();
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 1; i <= 19; i++) drive(8'(i), 1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; gmii_rxd = 8'd20;
        @(negedge clk);
        compared++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 8'h00) begin
            mismatched++; $display("[TB] FAIL midrst_outputs got %b/%b/%h want 0/0/00", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
        end
        preBeats = beatData.size();
        compared++;
        if (preBeats != 18 - STRIP) begin
            mismatched++; $display("[TB] FAIL midrst_pre_beats got %0d want %0d", preBeats, 18 - STRIP);
        end
        for (int i = 21; i <= 30; i++) drive(8'(i), 1'b1, 1'b0);
        idle(2);
        foreach (beatLast[k]) if (beatLast[k]) lastCnt++;
        compared++;
        if (beatData.size() != preBeats || lastCnt != 0) begin
            mismatched++; $display("[TB] FAIL midrst_drop got beats=%0d tlast=%0d want %0d/0", beatData.size(), lastCnt, preBeats);
        end
        compared++;
        if (frame_count !== 32'd0 || error_count !== 32'd0) begin
            mismatched++; $display("[TB] FAIL midrst_counts got %0d/%0d want 0/0", frame_count, error_count);
        end
        sendFrame(7, 8, 8'hC0, -1, expTs, firstCyc);
        idle(2);
        compared++;
        if (beatData.size() != preBeats + 8 - STRIP || frame_count !== 32'd1 || error_count !== 32'd0) begin
            mismatched++; $display("[TB] FAIL midrst_next got beats=%0d f=%0d e=%0d want %0d/1/0", beatData.size(), frame_count, error_count, preBeats + 8 - STRIP);
        end
    endtask

    task automatic test_boundaries();
        logic [63:0] expTs;
        int firstCyc;
        int expFrame, expErr, expBeats;
        doReset();
        for (int i = 0; i < 3; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (beatData.size() != 0 || error_count !== 32'd1 || frame_count !== 32'd0) begin
            mismatched++; $display("[TB] FAIL nopayload got beats=%0d err=%0d frm=%0d want 0/1/0", beatData.size(), error_count, frame_count);
        end
        drive(8'hD5, 1'b1, 1'b0); drive(8'h11, 1'b1, 1'b0);
        idle(2);
        compared++;
        if (beatData.size() != 0 || error_count !== 32'd2) begin
            mismatched++; $display("[TB] FAIL sfd_in_idle got beats=%0d err=%0d want 0/2", beatData.size(), error_count);
        end
        sendFrame(1, 6, 8'h30, -1, expTs, firstCyc);
        sendFrame(10, 6, 8'h50, -1, expTs, firstCyc);
        idle(2);
        compared++;
        if (beatData.size() != 2 * (6 - STRIP) || frame_count !== 32'd2) begin
            mismatched++; $display("[TB] FAIL preamble_len got beats=%0d frm=%0d want %0d/2", beatData.size(), frame_count, 2 * (6 - STRIP));
        end
        clearQueues();
        sendFrame(7, 3, 8'hE0, -1, expTs, firstCyc);
        idle(2);
        expBeats = (3 > STRIP) ? 3 : 0;
        expFrame = (3 > STRIP) ? 3 : 2;
        expErr   = (3 > STRIP) ? 2 : 3;
        compared++;
        if (beatData.size() != expBeats || frame_count !== 32'(expFrame) || error_count !== 32'(expErr)) begin
            mismatched++; $display("[TB] FAIL short_payload got beats=%0d frm=%0d err=%0d want %0d/%0d/%0d", beatData.size(), frame_count, error_count, expBeats, expFrame, expErr);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_payload_error();
        test_bad_preamble();
        test_back_to_back();
        test_reset_mid_frame();
        test_boundaries();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
